// File: rtl/pixel_arbiter_2d.sv
// Two-level (row, then column) round-robin arbiter over a snapshot of one pixel block's request matrix.
// Define ARB_GRP_COUNT_EN to add the grp_count_o accepted-event counter.
module pixel_arbiter_2d #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int ROW_ADD = $clog2(ROWS),
    parameter int COL_ADD = $clog2(COLS),
    parameter int CNT_W   = $clog2(ROWS*COLS+1)
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      enable_i,
    input  logic [ROWS-1:0][COLS-1:0] req_i,
    input  logic                      gnt_ready_i,
    output logic [ROWS-1:0][COLS-1:0] gnt_o,
    output logic                      gnt_valid_o,
    output logic [ROW_ADD-1:0]        x_add_o,
    output logic [COL_ADD-1:0]        y_add_o,
    output logic                      req_o,
    output logic                      active_o,
    output logic                      grp_release_o
`ifdef ARB_GRP_COUNT_EN
    ,
    output logic [CNT_W-1:0]          grp_count_o
`endif
);

    typedef enum logic [1:0] {IDLE, ROW_SEL, COL_GRANT, RELEASE} state_t;

    state_t                    state;
    state_t                    next_state;
    logic [ROWS-1:0][COLS-1:0] snap;
    logic [ROW_ADD-1:0]        row_ptr;
    logic                      row_found;
    logic [ROW_ADD-1:0]        found_row;
    logic [COL_ADD-1:0]        first_col;
    logic [COLS-1:0]           row_rest;
    logic                      has_more;
    logic [COL_ADD-1:0]        next_col;
    logic                      transfer;
    logic                      abort;
    logic                      start;

    if (CNT_W < $clog2(ROWS*COLS+1)) begin : g_cnt_w_check
        $error("pixel_arbiter_2d: CNT_W cannot hold ROWS*COLS events");
    end

    function automatic logic [ROW_ADD-1:0] wrap_row(input int r);
        wrap_row = (r >= ROWS) ? ROW_ADD'(r - ROWS) : ROW_ADD'(r);
    endfunction

    function automatic logic [COL_ADD-1:0] lowest_col(input logic [COLS-1:0] bits);
        lowest_col = '0;
        for (int c = COLS-1; c >= 0; c--) begin
            if (bits[c]) lowest_col = COL_ADD'(c);
        end
    endfunction

    assign transfer = gnt_valid_o & gnt_ready_i;
    assign abort    = (state != IDLE) & ~enable_i;
    assign start    = (state == IDLE) & enable_i & (|req_i);

    // Circular row search: scanning downwards lets the row nearest row_ptr win.
    always_comb begin
        row_found = 1'b0;
        found_row = '0;
        for (int i = ROWS-1; i >= 0; i--) begin
            if (|snap[wrap_row(int'(row_ptr) + i)]) begin
                row_found = 1'b1;
                found_row = wrap_row(int'(row_ptr) + i);
            end
        end
        first_col = lowest_col(snap[found_row]);
    end

    always_comb begin
        row_rest          = snap[x_add_o];
        row_rest[y_add_o] = 1'b0;
        has_more          = |row_rest;
        next_col          = lowest_col(row_rest);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = ROW_SEL;
            ROW_SEL:   next_state = row_found ? COL_GRANT : RELEASE;
            COL_GRANT: if (transfer && !has_more) next_state = ROW_SEL;
            RELEASE:   next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    always_comb begin
        req_o = |req_i;
        gnt_o = '0;
        if (gnt_valid_o) gnt_o[x_add_o][y_add_o] = 1'b1;
    end

    // An abort drops the pending grant and the snapshot but keeps row_ptr for fairness.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            snap          <= '0;
            row_ptr       <= '0;
            gnt_valid_o   <= 1'b0;
            x_add_o       <= '0;
            y_add_o       <= '0;
            active_o      <= 1'b0;
            grp_release_o <= 1'b0;
        end else begin
            active_o      <= (next_state != IDLE);
            grp_release_o <= 1'b0;
            if (abort) begin
                snap        <= '0;
                gnt_valid_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) snap <= req_i;
                    end
                    ROW_SEL: begin
                        if (row_found) begin
                            x_add_o     <= found_row;
                            y_add_o     <= first_col;
                            gnt_valid_o <= 1'b1;
                        end else begin
                            grp_release_o <= 1'b1;
                        end
                    end
                    COL_GRANT: begin
                        if (transfer) begin
                            snap[x_add_o][y_add_o] <= 1'b0;
                            if (has_more) begin
                                y_add_o <= next_col;
                            end else begin
                                gnt_valid_o <= 1'b0;
                                row_ptr     <= wrap_row(int'(x_add_o) + 1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ARB_GRP_COUNT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_ni || abort || start) grp_count_o <= '0;
        else if (transfer)               grp_count_o <= grp_count_o + CNT_W'(1);
    end
`endif

endmodule
